// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester and transmitter handshake signals around the UART TX arbiter.
// The master side is the arbiter; the slave side is the requesters plus the transmitter.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 9,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      uart_start;
    logic [DATA_W-1:0]         uart_data;
    logic                      uart_ready;
    logic                      uart_busy;
    logic [ID_W-1:0]           grant_id;
    logic                      active;
    logic                      timeout_err;
    logic                      clear_err;

    modport master (
        input  req_valid,
        input  req_data,
        input  uart_ready,
        input  uart_busy,
        input  clear_err,
        output req_ready,
        output uart_start,
        output uart_data,
        output grant_id,
        output active,
        output timeout_err
    );

    modport slave (
        output req_valid,
        output req_data,
        output uart_ready,
        output uart_busy,
        output clear_err,
        input  req_ready,
        input  uart_start,
        input  uart_data,
        input  grant_id,
        input  active,
        input  timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ requesters
// and sequences the start/busy/ready handshake, flagging a transmitter that never starts.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 9,
    parameter int ACK_TIMEOUT = 16,
    parameter int ID_W        = $clog2(NUM_REQ)
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.master bus
);

    localparam int                TMR_W     = $clog2(ACK_TIMEOUT);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [ID_W:0]     NUM_REQ_W = (ID_W + 1)'(NUM_REQ);
    localparam logic [ID_W-1:0]   PTR_RST   = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic [DATA_W-1:0]  uart_data_q, uart_data_d;
    logic               uart_start_q, uart_start_d;
    logic               active_q, active_d;
    logic               timeout_err_q, timeout_err_d;
    logic [TMR_W-1:0]   timer_q, timer_d;

    logic [DATA_W-1:0]  words [NUM_REQ];
    logic [ID_W-1:0]    winner;
    logic               win_found;
    logic [ID_W:0]      cand;
    logic               accept;
    logic               set_err;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
        assign words[i] = bus.req_data[i*DATA_W +: DATA_W];
    end

    // Search upward from the slot after the last winner, wrapping, so every
    // continuously valid requester is reached within NUM_REQ-1 other grants.
    always_comb begin
        winner    = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = {1'b0, ptr_q} + (ID_W + 1)'(off);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            if (!win_found && bus.req_valid[cand[ID_W-1:0]]) begin
                win_found = 1'b1;
                winner    = cand[ID_W-1:0];
            end
        end
    end

    // The acceptance pulse is suppressed during reset so no word is handed
    // off while the sequencer is being forced back to IDLE.
    assign accept        = (state_q == IDLE) && win_found && bus.uart_ready && !rst;
    assign bus.req_ready = accept ? (NUM_REQ'(1) << winner) : '0;

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_id_d    = grant_id_q;
        uart_data_d   = uart_data_q;
        timer_d       = timer_q;
        set_err       = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    uart_data_d = words[winner];
                    grant_id_d  = winner;
                    ptr_d       = winner;
                    state_d     = START;
                end
            end
            START: begin
                timer_d = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.uart_busy) begin
                    state_d = WAIT_DONE;
                end else if (timer_q == TMR_LAST) begin
                    set_err = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!bus.uart_busy && bus.uart_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new timeout wins over a simultaneous clear.
        timeout_err_d = timeout_err_q;
        if (bus.clear_err) begin
            timeout_err_d = 1'b0;
        end
        if (set_err) begin
            timeout_err_d = 1'b1;
        end

        uart_start_d = (state_d == START);
        active_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            ptr_q         <= PTR_RST;
            grant_id_q    <= '0;
            uart_data_q   <= '0;
            uart_start_q  <= 1'b0;
            active_q      <= 1'b0;
            timeout_err_q <= 1'b0;
            timer_q       <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_id_q    <= grant_id_d;
            uart_data_q   <= uart_data_d;
            uart_start_q  <= uart_start_d;
            active_q      <= active_d;
            timeout_err_q <= timeout_err_d;
            timer_q       <= timer_d;
        end
    end

    assign bus.uart_start  = uart_start_q;
    assign bus.uart_data   = uart_data_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.active      = active_q;
    assign bus.timeout_err = timeout_err_q;

endmodule
